// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
// Holds the FSM state type and the counter width helper.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/subtractor.sv
// Ripple subtractor built from a full-adder chain: diff = a + ~b + 1.
// borrow is the inverted carry out of the top bit.
module subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH-1:0] w_b_n;
  logic [WIDTH:0]   w_carry;

  assign w_b_n      = ~b;
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]      = a[i] ^ w_b_n[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_n[i]) | (a[i] & w_carry[i]) | (w_b_n[i] & w_carry[i]);
  end

  assign borrow = ~w_carry[WIDTH];

endmodule

// File: rtl/iter_divider.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// A zero divisor short-circuits to a RISC-V style result in a single edge.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_quo, w_quo_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_dvs, w_dvs_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_dbz, w_dbz_nxt;

  // Trial operands are one bit wider so a remainder MSB shifted out never reads as a borrow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dvs_ext;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_unused_diff_msb;

  assign w_shift           = {r_rem, r_quo[WIDTH-1]};
  assign w_dvs_ext         = {1'b0, r_dvs};
  assign w_unused_diff_msb = w_diff[WIDTH];

  subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_trial (
    .a      (w_shift),
    .b      (w_dvs_ext),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dvs_nxt   = r_dvs;
    w_cnt_nxt   = r_cnt;
    w_dbz_nxt   = r_dbz;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_dvs_nxt = divisor;
          if (divisor == '0) begin
            w_state_nxt = StDone;
            w_quo_nxt   = '1;
            w_rem_nxt   = dividend;
            w_cnt_nxt   = '0;
            w_dbz_nxt   = 1'b1;
          end else begin
            w_state_nxt = StBusy;
            w_quo_nxt   = dividend;
            w_rem_nxt   = '0;
            w_cnt_nxt   = CntLoad;
            w_dbz_nxt   = 1'b0;
          end
        end
      end
      StBusy: begin
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
        w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_cnt_nxt = r_cnt - CntOne;
        if (r_cnt == CntOne) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        // Retiring edge only returns to idle; the next accept waits a cycle.
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_dvs   <= w_dvs_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign out_valid   = (r_state == StDone);
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider at WIDTH=8: directed literals plus a
// queue-based arithmetic model checked every cycle a result is presented.
module tb_iter_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  iter_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  bit   front_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Model: plain integer division; zero divisor gives all-ones / dividend.
  // A result is due W edges after the accept edge, or on the accept edge for a zero divisor.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      front_seen = 1'b0;
    end else begin
      if (out_valid) begin
        check("ready_low_in_done", {63'd0, in_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got q=%0h r=%0h, want no result", quotient, remainder);
        end else begin
          check("model_quotient", {56'd0, quotient}, {56'd0, exp_q[0].q});
          check("model_remainder", {56'd0, remainder}, {56'd0, exp_q[0].r});
          check("model_div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_q[0].d});
          if (!front_seen) begin
            check("model_latency_cycle", 64'(cyc), 64'(exp_q[0].due));
            front_seen = 1'b1;
          end
          if (out_ready) begin
            exp_q.delete(0);
            front_seen = 1'b0;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        n_tests++;
        n_fail++;
        $display("FAIL result_timeout: got no out_valid by cycle %0d, want it at %0d",
                 cyc, exp_q[0].due);
        exp_q.delete(0);
        front_seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        if (divisor == '0) begin
          e.q   = '1;
          e.r   = dividend;
          e.d   = 1'b1;
          e.due = cyc + 1;
        end else begin
          e.q   = dividend / divisor;
          e.r   = dividend % divisor;
          e.d   = 1'b0;
          e.due = cyc + 1 + int'(W);
        end
        exp_q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_wait_ready: got in_ready=0 after %0d cycles, want 1", k);
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // elat counts edges from the accept edge to the edge that raises out_valid.
  task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                         input int elat);
    int start;
    int k = 0;
    send(a, b);
    start = cyc;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got out_valid=0, want 1 within 40 cycles", name);
    end else begin
      check({name, "_quotient"}, {56'd0, quotient}, {56'd0, eq});
      check({name, "_remainder"}, {56'd0, remainder}, {56'd0, er});
      check({name, "_div_by_zero"}, {63'd0, div_by_zero}, {63'd0, ed});
      check({name, "_latency"}, 64'(cyc - start), 64'(elat));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_in_ready_after_retire"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #2;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_quotient", {56'd0, quotient}, 64'd0);
    check("reset_remainder", {56'd0, remainder}, 64'd0);
    check("reset_div_by_zero", {63'd0, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_lit("div_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    // Zero divisor: result visible in the cycle right after the accept cycle.
    run_lit("div_5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
    run_lit("div_ff_1", 8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0, 8);
    run_lit("div_3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 8);
    run_lit("div_80_ff", 8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, 8);

    // Backpressure: hold the result, offer a competing request, then retire with in_valid high.
    send(8'd100, 8'd7);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 8'd3;
      divisor  = 8'd1;
      @(posedge clk);
      #1;
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_quotient", {56'd0, quotient}, 64'd14);
      check("hold_remainder", {56'd0, remainder}, 64'd2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("retire_in_ready", {63'd0, in_ready}, 64'd1);
    check("retire_no_accept_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("retire_still_idle", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of a busy operation.
    send(8'd100, 8'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    check("midreset_quotient", {56'd0, quotient}, 64'd0);
    check("midreset_remainder", {56'd0, remainder}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_lit("div_200_9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 8);

    // Back-to-back random sweep against the model.
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
      send(a, b);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("sweep_drained", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
